// File: rtl/platform_pio_edge_irq.sv
// Input-only PIO with synchroniser, per-bit edge capture and IRQ mask.
// Avalon-MM slave: 0=data, 1=reserved, 2=irq_mask, 3=edge_capture.
module platform_pio_edge_irq #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_CNT = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_wd;

  assign data_sync = sync_q[SYNC_STAGES-1];
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign wr_en     = chipselect & ~write_n;
  assign armed     = (arm_cnt == ARM_CNT);
  assign rise      = data_sync & ~data_d;
  assign fall      = ~data_sync & data_d;
  assign clr       = (wr_en && address == 2'd3) ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Edges are ignored until the sync chain and data_d hold post-reset samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_d  <= '0;
      arm_cnt <= '0;
    end else begin
      data_d <= data_sync;
      if (arm_cnt != ARM_CNT)
        arm_cnt <= arm_cnt + CW'(1);
    end
  end

  always_comb begin
    edge_det = '0;
    if (armed) begin
      unique case (EDGE_TYPE)
        1:       edge_det = rise;
        2:       edge_det = fall;
        3:       edge_det = rise | fall;
        default: edge_det = '0;
      endcase
    end
  end

  // A fresh edge wins over a simultaneous W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == 2'd2)
        irq_mask <= wd;
      if (EDGE_TYPE == 0)
        edge_capture <= '0;
      else
        edge_capture <= (edge_capture & ~clr) | edge_det;
    end
  end

  always_comb begin
    rd_next = '0;
    unique case (address)
      2'd0:    rd_next = 32'(data_sync);
      2'd2:    rd_next = 32'(irq_mask);
      2'd3:    rd_next = 32'(edge_capture);
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= rd_next;
  end

  assign irq = (EDGE_TYPE == 0) ? |(data_sync & irq_mask)
                                : |(edge_capture & irq_mask);

endmodule

// File: tb/tb_platform_pio_edge_irq.sv
// Bench for platform_pio_edge_irq: three configurations driven in
// parallel and checked against a sample-history model.
module tb_platform_pio_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  platform_pio_edge_irq #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(2)) u_dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd0), .irq(irq0));

  platform_pio_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(3)) u_dut_level (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd1), .irq(irq1));

  platform_pio_edge_irq #(.WIDTH(8), .EDGE_TYPE(3), .SYNC_STAGES(4)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd2), .irq(irq2));

  // hist[m] = in_port sampled at the m-th posedge after reset release
  logic [7:0]  hist [$];
  int          n;
  logic [7:0]  m_mask [3];
  logic [7:0]  m_cap  [3];
  logic [31:0] m_rd   [3];

  function automatic int et(int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  function automatic int ss(int k);
    return k + 2;
  endfunction

  function automatic logic [7:0] sync_at(int m, int s);
    if (m >= s) return hist[m-s+1];
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      m_mask[k] = '0;
      m_cap[k]  = '0;
      m_rd[k]   = '0;
    end
  endtask

  task automatic model_clock();
    logic [7:0] a, b, det, clr;
    logic       wr;
    int         s;
    n++;
    hist.push_back(in_port);
    wr = chipselect && !write_n;
    for (int k = 0; k < 3; k++) begin
      s = ss(k);
      a = sync_at(n - 1, s);
      b = sync_at(n - 2, s);
      det = '0;
      if (n >= s + 2) begin
        if (et(k) == 1) det = a & ~b;
        if (et(k) == 2) det = ~a & b;
        if (et(k) == 3) det = a ^ b;
      end
      case (address)
        2'd0: m_rd[k] = {24'h0, a};
        2'd2: m_rd[k] = {24'h0, m_mask[k]};
        2'd3: m_rd[k] = {24'h0, m_cap[k]};
        default: m_rd[k] = '0;
      endcase
      clr = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
      if (et(k) != 0)
        m_cap[k] = (m_cap[k] & ~clr) | det;
      if (wr && address == 2'd2)
        m_mask[k] = writedata[7:0];
    end
  endtask

  task automatic check_all();
    logic [31:0] rd [3];
    logic        iq [3];
    logic        exp_irq;
    rd[0] = rd0; rd[1] = rd1; rd[2] = rd2;
    iq[0] = irq0; iq[1] = irq1; iq[2] = irq2;
    for (int k = 0; k < 3; k++) begin
      if (et(k) == 0)
        exp_irq = |(sync_at(n, ss(k)) & m_mask[k]);
      else
        exp_irq = |(m_cap[k] & m_mask[k]);
      chk($sformatf("readdata%0d", k), rd[k], m_rd[k]);
      chk($sformatf("irq%0d", k), {31'h0, iq[k]}, {31'h0, exp_irq});
    end
  endtask

  // Called at a negedge; returns at the following negedge after checking
  task automatic step(input logic cs, input logic wn, input logic [1:0] a,
                      input logic [31:0] wd, input logic [7:0] ip);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_port    = ip;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all();
  endtask

  task automatic rd_step(input logic [1:0] a);
    step(1'b1, 1'b1, a, 32'h0, in_port);
  endtask

  task automatic wr_step(input logic [1:0] a, input logic [31:0] wd);
    step(1'b1, 1'b0, a, wd, in_port);
  endtask

  task automatic do_reset(input logic [7:0] ip);
    in_port    = ip;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) begin
      @(negedge clk);
      check_all();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset(8'hFF);

    // inputs high through reset: no capture, data reads 0xFF
    repeat (8) rd_step(2'd0);
    repeat (3) rd_step(2'd3);
    chk("no_spurious_cap", rd0, 32'h0);
    chk("data_ff", {31'h0, irq0}, 32'h0);

    // bit3 rising edge with mask 0x08
    wr_step(2'd2, 32'h08);
    step(1'b0, 1'b1, 2'd3, 32'h0, 8'h00);
    repeat (6) rd_step(2'd3);
    step(1'b1, 1'b1, 2'd3, 32'h0, 8'h08);
    repeat (6) rd_step(2'd3);
    chk("cap_bit3", rd0, 32'h08);
    chk("irq_bit3", {31'h0, irq0}, 32'h1);

    // W1C with zero, then with 0x08
    wr_step(2'd3, 32'h00);
    rd_step(2'd3);
    wr_step(2'd3, 32'h08);
    rd_step(2'd3);
    chk("w1c_clear", rd0, 32'h0);

    // new edge coincides with W1C: set wins
    step(1'b0, 1'b1, 2'd3, 32'h0, 8'h00);
    repeat (6) rd_step(2'd3);
    wr_step(2'd3, 32'h08);
    step(1'b0, 1'b1, 2'd3, 32'h0, 8'h08);
    rd_step(2'd3);
    wr_step(2'd3, 32'h08);
    repeat (3) rd_step(2'd3);
    chk("set_wins", rd0, 32'h08);

    // level pulse on bit0
    wr_step(2'd2, 32'h01);
    step(1'b0, 1'b1, 2'd0, 32'h0, 8'h00);
    repeat (5) rd_step(2'd0);
    in_port = 8'h01;
    repeat (5) rd_step(2'd0);
    in_port = 8'h00;
    repeat (6) rd_step(2'd0);

    // reserved address and mask width
    wr_step(2'd2, 32'hFFFF_FFFF);
    rd_step(2'd1);
    chk("rd_reserved", rd1, 32'h0);
    rd_step(2'd2);
    chk("rd_mask", rd1, 32'h0000_00FF);
    wr_step(2'd0, 32'h1234_5678);
    wr_step(2'd1, 32'hFFFF_FFFF);
    rd_step(2'd1);

    // randomized traffic with occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ip;
      ip = in_port;
      if ($urandom_range(0, 3) == 0)
        ip = ip ^ 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        do_reset(ip);
      end else begin
        step(1'($urandom), 1'($urandom), 2'($urandom), $urandom, ip);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
